// File: rtl/prga_decrypt_if.sv
// Bundle of the control, S-RAM, ROM and decrypted-RAM signals of the RC4 PRGA decryptor.
// The slave modport is the decryptor; the master modport is the environment (memories and requester).
interface prga_decrypt_if;
  logic       start;
  logic       complete;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;
  logic [7:0] rom_address;
  logic [7:0] rom_q;
  logic [7:0] dec_address;
  logic [7:0] dec_data;
  logic       dec_wren;

  modport slave (
    input  start, s_q, rom_q,
    output complete, s_address, s_data, s_wren,
           rom_address, dec_address, dec_data, dec_wren
  );

  modport master (
    output start, s_q, rom_q,
    input  complete, s_address, s_data, s_wren,
           rom_address, dec_address, dec_data, dec_wren
  );
endinterface

// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation stage: walks the shuffled S array and XORs the keystream
// with the encrypted ROM bytes, writing MSG_LEN decrypted bytes per run.
module prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  prga_decrypt_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, INC_I, ADDR_I, READ_I, CALC_J, ADDR_J, READ_J,
    SWAP_I, SWAP_J, ADDR_F, READ_F, WRITE_D, CHECK_K, DONE
  } state_t;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t     state, next_state;
  logic [7:0] i, j, k;
  logic [7:0] si, sj, f, enc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      k     <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      f     <= 8'd0;
      enc   <= 8'd0;
    end else begin
      state <= next_state;
      case (state)
        INC_I:   i <= i + 8'd1;
        READ_I:  si <= bus.s_q;
        CALC_J:  j <= j + si;
        READ_J:  sj <= bus.s_q;
        READ_F: begin
          f   <= bus.s_q;
          enc <= bus.rom_q;
        end
        CHECK_K: if (k != LAST_K) k <= k + 8'd1;
        DONE: begin
          i <= 8'd0;
          j <= 8'd0;
          k <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Memory reads are presented for two states so the registered RAM/ROM output is captured in the second.
  always_comb begin
    next_state      = state;
    bus.complete    = 1'b0;
    bus.s_address   = 8'd0;
    bus.s_data      = 8'd0;
    bus.s_wren      = 1'b0;
    bus.rom_address = 8'd0;
    bus.dec_address = 8'd0;
    bus.dec_data    = 8'd0;
    bus.dec_wren    = 1'b0;
    case (state)
      IDLE:    if (bus.start) next_state = INC_I;
      INC_I:   next_state = ADDR_I;
      ADDR_I: begin
        bus.s_address = i;
        next_state    = READ_I;
      end
      READ_I: begin
        bus.s_address = i;
        next_state    = CALC_J;
      end
      CALC_J:  next_state = ADDR_J;
      ADDR_J: begin
        bus.s_address = j;
        next_state    = READ_J;
      end
      READ_J: begin
        bus.s_address = j;
        next_state    = SWAP_I;
      end
      SWAP_I: begin
        bus.s_address = i;
        bus.s_data    = sj;
        bus.s_wren    = 1'b1;
        next_state    = SWAP_J;
      end
      SWAP_J: begin
        bus.s_address = j;
        bus.s_data    = si;
        bus.s_wren    = 1'b1;
        next_state    = ADDR_F;
      end
      ADDR_F: begin
        bus.s_address   = si + sj;
        bus.rom_address = k;
        next_state      = READ_F;
      end
      READ_F: begin
        bus.s_address   = si + sj;
        bus.rom_address = k;
        next_state      = WRITE_D;
      end
      WRITE_D: begin
        bus.dec_address = k;
        bus.dec_data    = f ^ enc;
        bus.dec_wren    = 1'b1;
        next_state      = CHECK_K;
      end
      CHECK_K: next_state = (k == LAST_K) ? DONE : INC_I;
      DONE: begin
        bus.complete = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Scoreboard bench for prga_decrypt: a software RC4 PRGA predicts every decrypted write,
// with behavioural S-RAM/ROM models behind a 4-byte and a 256-byte instance.
module tb_prga_decrypt;

  logic clk;
  logic reset;

  prga_decrypt_if bus4 ();
  prga_decrypt_if bus256 ();

  prga_decrypt #(.MSG_LEN(4))   dut4   (.clk(clk), .reset(reset), .bus(bus4.slave));
  prga_decrypt #(.MSG_LEN(256)) dut256 (.clk(clk), .reset(reset), .bus(bus256.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int error_count = 0;
  int check_count = 0;
  int edge_count = 0;

  logic [7:0] s_mem4 [256];
  logic [7:0] dec_mem4 [256];
  logic [7:0] s_mem256 [256];
  logic [7:0] model_s [256];
  logic       load4 = 1'b0;
  logic       load256 = 1'b0;
  logic [7:0] enc_base = 8'h00;
  logic       enc_step = 1'b0;

  logic [15:0] exp4 [$];
  logic [15:0] exp256 [$];
  logic [15:0] e4, e256;

  int start_edge4 = 0, start_edge256 = 0;
  int s_cnt4 = 0, dec_cnt4 = 0, complete_cnt4 = 0, last_complete4 = 0;
  int s_cnt256 = 0, dec_cnt256 = 0, complete_cnt256 = 0, last_complete256 = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] enc_of(input logic [7:0] a);
    return enc_base ^ (enc_step ? a : 8'h00);
  endfunction

  always @(posedge clk) edge_count <= edge_count + 1;

  // Behavioural one-cycle-latency memories; a load request rewrites S to the identity permutation.
  always @(posedge clk) begin
    if (load4) for (int x = 0; x < 256; x++) s_mem4[x] <= 8'(x);
    else if (bus4.s_wren) s_mem4[bus4.s_address] <= bus4.s_data;
    bus4.s_q   <= s_mem4[bus4.s_address];
    bus4.rom_q <= enc_of(bus4.rom_address);
    if (bus4.dec_wren) dec_mem4[bus4.dec_address] <= bus4.dec_data;
  end

  always @(posedge clk) begin
    if (load256) for (int x = 0; x < 256; x++) s_mem256[x] <= 8'(x);
    else if (bus256.s_wren) s_mem256[bus256.s_address] <= bus256.s_data;
    bus256.s_q   <= s_mem256[bus256.s_address];
    bus256.rom_q <= enc_of(bus256.rom_address);
  end

  always @(negedge clk) begin
    if (bus4.dec_wren) begin
      dec_cnt4++;
      if (exp4.size() == 0) checkOutput("dec4_unexpected", 32'd1, 32'd0);
      else begin
        e4 = exp4.pop_front();
        checkOutput("dec4_addr", {24'd0, bus4.dec_address}, {24'd0, e4[15:8]});
        checkOutput("dec4_data", {24'd0, bus4.dec_data}, {24'd0, e4[7:0]});
      end
    end
    if (bus4.s_wren) s_cnt4++;
    if (bus4.s_wren && bus4.dec_wren) checkOutput("wren4_overlap", 32'd1, 32'd0);
    if (bus4.complete) begin
      complete_cnt4++;
      last_complete4 = edge_count - start_edge4 + 1;
    end
  end

  always @(negedge clk) begin
    if (bus256.dec_wren) begin
      dec_cnt256++;
      if (exp256.size() == 0) checkOutput("dec256_unexpected", 32'd1, 32'd0);
      else begin
        e256 = exp256.pop_front();
        checkOutput("dec256_addr", {24'd0, bus256.dec_address}, {24'd0, e256[15:8]});
        checkOutput("dec256_data", {24'd0, bus256.dec_data}, {24'd0, e256[7:0]});
      end
    end
    if (bus256.s_wren) s_cnt256++;
    if (bus256.s_wren && bus256.dec_wren) checkOutput("wren256_overlap", 32'd1, 32'd0);
    if (bus256.complete) begin
      complete_cnt256++;
      last_complete256 = edge_count - start_edge256 + 1;
    end
  end

  // Software RC4 PRGA; model_s carries S across back-to-back runs exactly like the RAM does.
  task automatic modelRun(input int len, input bit big);
    logic [7:0] i, j, t, idx, f;
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < len; k++) begin
      i = i + 8'd1;
      j = j + model_s[i];
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
      idx = model_s[i] + model_s[j];
      f = model_s[idx] ^ enc_of(8'(k));
      if (big) exp256.push_back({8'(k), f});
      else exp4.push_back({8'(k), f});
    end
  endtask

  task automatic reloadS(input bit big);
    @(negedge clk);
    if (big) load256 = 1'b1; else load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    load256 = 1'b0;
    for (int x = 0; x < 256; x++) model_s[x] = 8'(x);
  endtask

  task automatic applyStimulus(input bit big, input bit hold);
    @(negedge clk);
    if (big) bus256.start = 1'b1; else bus4.start = 1'b1;
    @(posedge clk);
    #1;
    if (big) start_edge256 = edge_count; else start_edge4 = edge_count;
    if (!hold) begin
      bus4.start = 1'b0;
      bus256.start = 1'b0;
    end
  endtask

  task automatic waitComplete(input bit big, input int target, input int bound);
    for (int c = 0; c < bound; c++) begin
      if ((big ? complete_cnt256 : complete_cnt4) >= target) break;
      @(posedge clk);
      #1;
    end
    checkOutput(big ? "complete256_seen" : "complete4_seen",
                32'((big ? complete_cnt256 : complete_cnt4) >= target), 32'd1);
  endtask

  task automatic runShort(input string tag, input logic [7:0] enc_val, input bit poke,
                          input logic [31:0] exp_dec);
    int base_s, base_d, base_c;
    reloadS(1'b0);
    enc_base = enc_val;
    enc_step = 1'b0;
    modelRun(4, 1'b0);
    base_s = s_cnt4;
    base_d = dec_cnt4;
    base_c = complete_cnt4;
    applyStimulus(1'b0, 1'b0);
    if (poke) begin
      repeat (5) @(negedge clk);
      bus4.start = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
    end
    waitComplete(1'b0, base_c + 1, 200);
    checkOutput({tag, "_complete_cycle"}, 32'(last_complete4), 32'd49);
    repeat (30) @(negedge clk);
    checkOutput({tag, "_complete_count"}, 32'(complete_cnt4 - base_c), 32'd1);
    checkOutput({tag, "_s_wren_count"}, 32'(s_cnt4 - base_s), 32'd8);
    checkOutput({tag, "_dec_wren_count"}, 32'(dec_cnt4 - base_d), 32'd4);
    checkOutput({tag, "_sb_left"}, 32'(exp4.size()), 32'd0);
    for (int x = 0; x < 4; x++)
      checkOutput({tag, "_dec_byte"}, {24'd0, dec_mem4[x]}, {24'd0, exp_dec[31-8*x -: 8]});
  endtask

  initial begin
    int base_s, base_d, base_c;
    reset = 1'b1;
    bus4.start = 1'b0;
    bus256.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_complete", {31'd0, bus4.complete}, 32'd0);
    checkOutput("rst_s_wren", {31'd0, bus4.s_wren}, 32'd0);
    checkOutput("rst_dec_wren", {31'd0, bus4.dec_wren}, 32'd0);
    checkOutput("rst_s_address", {24'd0, bus4.s_address}, 32'd0);
    checkOutput("rst_s_data", {24'd0, bus4.s_data}, 32'd0);
    checkOutput("rst_rom_address", {24'd0, bus4.rom_address}, 32'd0);
    checkOutput("rst_dec_address", {24'd0, bus4.dec_address}, 32'd0);
    checkOutput("rst_dec_data", {24'd0, bus4.dec_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_complete", {31'd0, bus4.complete}, 32'd0);
    checkOutput("idle_s_wren", {31'd0, bus4.s_wren}, 32'd0);

    $display("[TB] identity S, enc 00");
    runShort("enc00", 8'h00, 1'b0, 32'h02_05_07_0D);
    checkOutput("s2", {24'd0, s_mem4[2]}, 32'h03);
    checkOutput("s3", {24'd0, s_mem4[3]}, 32'h05);
    checkOutput("s4", {24'd0, s_mem4[4]}, 32'h09);
    checkOutput("s5", {24'd0, s_mem4[5]}, 32'h02);
    checkOutput("s9", {24'd0, s_mem4[9]}, 32'h04);

    $display("[TB] identity S, enc FF");
    runShort("encFF", 8'hFF, 1'b0, 32'hFD_FA_F8_F2);

    $display("[TB] start pulsed mid-run");
    runShort("poke", 8'h00, 1'b1, 32'h02_05_07_0D);

    $display("[TB] reset in ADDR_J of the second byte");
    reloadS(1'b0);
    enc_base = 8'h00;
    modelRun(4, 1'b0);
    base_s = s_cnt4;
    base_d = dec_cnt4;
    base_c = complete_cnt4;
    applyStimulus(1'b0, 1'b0);
    for (int c = 0; c < 100 && edge_count < start_edge4 + 16; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort_addr_j", {24'd0, bus4.s_address}, 32'd3);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abort_s_wren_count", 32'(s_cnt4 - base_s), 32'd2);
    checkOutput("abort_dec_wren_count", 32'(dec_cnt4 - base_d), 32'd1);
    checkOutput("abort_complete_count", 32'(complete_cnt4 - base_c), 32'd0);
    checkOutput("abort_sb_left", 32'(exp4.size()), 32'd3);
    while (exp4.size() > 0) void'(exp4.pop_front());
    runShort("restart", 8'h00, 1'b0, 32'h02_05_07_0D);

    $display("[TB] start held high, back-to-back runs");
    reloadS(1'b0);
    enc_base = 8'h00;
    modelRun(4, 1'b0);
    modelRun(4, 1'b0);
    base_s = s_cnt4;
    base_d = dec_cnt4;
    base_c = complete_cnt4;
    applyStimulus(1'b0, 1'b1);
    waitComplete(1'b0, base_c + 1, 200);
    checkOutput("b2b_first_cycle", 32'(last_complete4), 32'd49);
    waitComplete(1'b0, base_c + 2, 200);
    bus4.start = 1'b0;
    checkOutput("b2b_second_cycle", 32'(last_complete4), 32'd99);
    repeat (30) @(negedge clk);
    checkOutput("b2b_complete_count", 32'(complete_cnt4 - base_c), 32'd2);
    checkOutput("b2b_s_wren_count", 32'(s_cnt4 - base_s), 32'd16);
    checkOutput("b2b_dec_wren_count", 32'(dec_cnt4 - base_d), 32'd8);
    checkOutput("b2b_sb_left", 32'(exp4.size()), 32'd0);

    $display("[TB] MSG_LEN=256, identity S, varying enc");
    reloadS(1'b1);
    enc_base = 8'h3C;
    enc_step = 1'b1;
    modelRun(256, 1'b1);
    applyStimulus(1'b1, 1'b0);
    waitComplete(1'b1, 1, 4000);
    repeat (20) @(negedge clk);
    checkOutput("long_complete_cycle", 32'(last_complete256), 32'd3073);
    checkOutput("long_complete_count", 32'(complete_cnt256), 32'd1);
    checkOutput("long_dec_wren_count", 32'(dec_cnt256), 32'd256);
    checkOutput("long_s_wren_count", 32'(s_cnt256), 32'd512);
    checkOutput("long_sb_left", 32'(exp256.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/prga_decrypt.md
PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 Parameter: MSG_LEN, default 32, number of message bytes decrypted per run (legal 1..256).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  level request; sampled only in IDLE.
REQ-005 Port: complete  output  1  one-cycle pulse: run finished.
REQ-006 Port: s_address  output  8  S-RAM address (shuffled state array).
REQ-007 Port: s_data  output  8  S-RAM write data.
REQ-008 Port: s_wren  output  1  S-RAM write enable.
REQ-009 Port: s_q  input  8  S-RAM read data, valid one cycle after the address is presented.
REQ-010 Port: rom_address  output  8  encrypted-message ROM address.
REQ-011 Port: rom_q  input  8  ROM read data, same one-cycle latency.
REQ-012 Port: dec_address  output  8  decrypted-message RAM address.
REQ-013 Port: dec_data  output  8  decrypted-message RAM write data.
REQ-014 Port: dec_wren  output  1  decrypted-message RAM write enable.

Function
REQ-015 The block SHALL implement the RC4 PRGA: i=j=0; per byte k: i=i+1; j=j+s[i]; swap s[i],s[j]; f=s[s[i]+s[j]]; dec[k]=f XOR enc[k].
REQ-016 All index and sum arithmetic SHALL be 8-bit modulo 256; i wraps 255->0 without special handling.
REQ-017 FSM states, one cycle each, in this order: IDLE, INC_I, ADDR_I, READ_I, CALC_J, ADDR_J, READ_J, SWAP_I, SWAP_J, ADDR_F, READ_F, WRITE_D, CHECK_K, DONE.
REQ-018 IDLE->INC_I when start=1; otherwise stay in IDLE.
REQ-019 INC_I: i<=i+1.  ADDR_I/READ_I: s_address=i; READ_I captures si<=s_q.
REQ-020 CALC_J: j<=j+si.  ADDR_J/READ_J: s_address=j; READ_J captures sj<=s_q.
REQ-021 SWAP_I: s_address=i, s_data=sj, s_wren=1.  SWAP_J: s_address=j, s_data=si, s_wren=1.
REQ-022 ADDR_F/READ_F: s_address=si+sj, rom_address=k; READ_F captures f<=s_q and enc<=rom_q.
REQ-023 WRITE_D: dec_address=k, dec_data=f XOR enc, dec_wren=1.
REQ-024 CHECK_K: if k==MSG_LEN-1 go to DONE, else k<=k+1 and go to INC_I.
REQ-025 DONE: complete=1, clear i, j and k to 0, return to IDLE.
REQ-026 s_wren and dec_wren SHALL be high only in the states listed above and never simultaneously.
REQ-027 When i==j, the swap SHALL write the same value twice, leaving S unchanged.
REQ-028 start SHALL be ignored in every state except IDLE; start held high SHALL begin a new run in the cycle after DONE->IDLE.
REQ-029 Latency: if start is sampled at edge 0, complete SHALL be high during cycle 12*MSG_LEN+1 only.

Reset
REQ-030 With reset=1 at a rising edge, state SHALL become IDLE and i, j, k, si, sj, f and enc SHALL become 0.
REQ-031 During and after reset, complete, s_wren and dec_wren SHALL be 0; address and data outputs SHALL be 0.
REQ-032 Reset mid-run SHALL abort with no further writes; S-RAM and decrypted-RAM contents already written are not restored.

Verification
REQ-033 S[x]=x, MSG_LEN=4, enc all 0x00, start pulse -> dec = 02,05,07,0D; S[2]=03, S[3]=05, S[4]=09, S[5]=02, S[9]=04.
REQ-034 Same setup, enc all 0xFF -> dec = FD,FA,F8,F2; complete high exactly at cycle 49 after the start sample, for one cycle.
REQ-035 Pulse start during byte 1 of a run -> no effect; results and complete timing identical to REQ-033.
REQ-036 Assert reset in the ADDR_J state of byte 2 -> no further wren and no complete; reload S to identity, restart -> REQ-033 results.
REQ-037 MSG_LEN=256, S identity -> i wraps to 0 at k=255; exactly 256 dec_wren pulses and 512 s_wren pulses; results match a software RC4 PRGA model.
REQ-038 Hold start high continuously -> back-to-back runs, with one IDLE cycle between each complete and the next INC_I.
